// File: rtl/branch_predictor_gshare.sv
// Fetch-stage predictor: N-way BTB plus a PHT of saturating counters, cleared by a post-reset sweep.
// Define BP_GSHARE_EN to XOR global history into the PHT index; otherwise counters are per-pc bimodal.
module branch_predictor_gshare #(
    parameter int WAYS        = 2,
    parameter int ENTRIES     = 512,
    parameter int PHT_ENTRIES = 1024,
    parameter int CTR_W       = 2,
    parameter int HIST_W      = 10,
    parameter int TAG_W       = 20,
    parameter int ID_W        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     next_pc,
    input  logic            new_mem_request,
    input  logic [31:0]     if_pc,
    input  logic [ID_W-1:0] pc_id,
    input  logic            pc_id_assigned,
    output logic [31:0]     predicted_pc,
    output logic            use_prediction,
    output logic            predict_taken,
    output logic            is_branch,
    output logic            is_return,
    output logic            is_call,
    input  logic            br_valid,
    input  logic [ID_W-1:0] br_id,
    input  logic [31:0]     br_pc,
    input  logic [31:0]     br_target_pc,
    input  logic            br_taken,
    input  logic            br_is_branch,
    input  logic            br_is_return,
    input  logic            br_is_call,
    output logic [31:0]     branch_flush_pc,
    output logic            ras_branch_retired,
    output logic            init_done
);
    localparam int LOG_E  = $clog2(ENTRIES);
    localparam int LOG_P  = $clog2(PHT_ENTRIES);
    localparam int INIT_N = (ENTRIES > PHT_ENTRIES) ? ENTRIES : PHT_ENTRIES;
    localparam int LOG_I  = $clog2(INIT_N);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BANK_W = TAG_W + 4;
    localparam int IDS    = 2 ** ID_W;
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((2 ** (CTR_W - 1)) - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [LOG_I-1:0] init_idx_q, init_idx_d;
    logic [WAY_W-1:0] rr_q, rr_d;
    logic             rd_ok_q, rd_ok_d;

    logic run, init_we, upd_we;
    assign run     = (state_q == ST_RUN);
    assign init_we = ~rst & ~run;
    assign upd_we  = ~rst & run & br_valid;

    logic [LOG_E-1:0] rd_set, br_set, bank_waddr;
    logic [TAG_W-1:0] if_tag, br_tag;
    logic [LOG_P-1:0] lookup_pi;
    assign rd_set = next_pc[2 +: LOG_E];
    assign br_set = br_pc[2 +: LOG_E];
    assign if_tag = if_pc[2 + LOG_E +: TAG_W];
    assign br_tag = br_pc[2 + LOG_E +: TAG_W];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;
    assign lookup_pi = next_pc[2 +: LOG_P] ^ LOG_P'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (upd_we && br_is_branch)
            ghr_d = {ghr_q[HIST_W-2:0], br_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    assign lookup_pi = next_pc[2 +: LOG_P];
`endif

    // Metadata captured at fetch, replayed at resolution by instruction ID
    logic [CTR_W-1:0] meta_ctr  [IDS];
    logic [LOG_P-1:0] meta_pi   [IDS];
    logic             meta_hit  [IDS];
    logic             meta_used [IDS];
    logic [WAYS-1:0]  meta_way  [IDS];

    logic [CTR_W-1:0] m_ctr, ctr_upd;
    logic [LOG_P-1:0] m_pi;
    logic             m_hit, m_used;
    logic [WAYS-1:0]  m_way;
    assign m_ctr  = meta_ctr[br_id];
    assign m_pi   = meta_pi[br_id];
    assign m_hit  = meta_hit[br_id];
    assign m_used = meta_used[br_id];
    assign m_way  = meta_way[br_id];

    logic [WAYS-1:0][BANK_W-1:0] bank_rd;
    logic [WAYS-1:0][31:0]       tgt_rd;
    logic [WAYS-1:0]             match, hit_oh, rr_oh;
    logic [BANK_W-1:0]           bank_wdata;

    assign bank_waddr = init_we ? init_idx_q[LOG_E-1:0] : br_set;
    assign bank_wdata = init_we ? '0 : {1'b1, br_tag, br_is_branch, br_is_return, br_is_call};

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [BANK_W-1:0] bank_mem [ENTRIES];
            logic [31:0]       tgt_mem  [ENTRIES];
            logic [BANK_W-1:0] bank_rd_q;
            logic [31:0]       tgt_rd_q;
            logic              bank_we, tgt_we;

            assign bank_we = init_we | (upd_we & m_way[gi]);
            // Target is kept on a not-taken hit so a later taken outcome still redirects correctly
            assign tgt_we  = upd_we & m_way[gi] & (~m_hit | br_taken);

            always_ff @(posedge clk) begin
                if (bank_we) bank_mem[bank_waddr] <= bank_wdata;
                if (tgt_we)  tgt_mem[bank_waddr]  <= br_target_pc;
                if (new_mem_request) begin
                    bank_rd_q <= bank_mem[rd_set];
                    tgt_rd_q  <= tgt_mem[rd_set];
                end
            end

            assign bank_rd[gi] = bank_rd_q;
            assign tgt_rd[gi]  = tgt_rd_q;
            assign match[gi]   = rd_ok_q & bank_rd_q[BANK_W-1] & (bank_rd_q[3 +: TAG_W] == if_tag);
            assign rr_oh[gi]   = (rr_q == WAY_W'(gi));
        end
    endgenerate

    logic [CTR_W-1:0] pht_mem [PHT_ENTRIES];
    logic [CTR_W-1:0] ctr_rd_q, pht_wdata;
    logic [LOG_P-1:0] pi_rd_q, pht_waddr;
    logic             pht_we;

    assign pht_we    = init_we | (upd_we & br_is_branch);
    assign pht_waddr = init_we ? init_idx_q[LOG_P-1:0] : m_pi;
    assign pht_wdata = init_we ? CTR_WEAK_NT : ctr_upd;

    always_ff @(posedge clk) begin
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
        if (new_mem_request) begin
            ctr_rd_q <= pht_mem[lookup_pi];
            pi_rd_q  <= lookup_pi;
        end
    end

    always_comb begin
        ctr_upd = m_ctr;
        if (!m_hit)
            ctr_upd = br_taken ? CTR_MAX : '0;
        else if (br_taken) begin
            if (m_ctr != CTR_MAX) ctr_upd = m_ctr + CTR_W'(1);
        end else if (m_ctr != '0)
            ctr_upd = m_ctr - CTR_W'(1);
    end

    logic [WAY_W-1:0] hit_sel;
    logic             hit;
    logic [2:0]       hit_type;

    always_comb begin
        hit_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (match[w]) hit_sel = WAY_W'(w);
    end

    assign hit      = |match;
    assign hit_oh   = match & ~(match - WAYS'(1));
    assign hit_type = hit ? bank_rd[hit_sel][2:0] : 3'b000;

    assign predicted_pc   = tgt_rd[hit_sel];
    assign is_branch      = hit_type[2];
    assign is_return      = hit_type[1];
    assign is_call        = hit_type[0];
    assign predict_taken  = run & (~hit_type[2] | ctr_rd_q[CTR_W-1]);
    assign use_prediction = run & hit & (~hit_type[2] | ctr_rd_q[CTR_W-1]);

    always_ff @(posedge clk) begin
        if (pc_id_assigned) begin
            meta_ctr[pc_id]  <= ctr_rd_q;
            meta_pi[pc_id]   <= pi_rd_q;
            meta_hit[pc_id]  <= hit;
            meta_used[pc_id] <= use_prediction;
            meta_way[pc_id]  <= hit ? hit_oh : rr_oh;
        end
    end

    assign branch_flush_pc    = br_target_pc;
    assign ras_branch_retired = upd_we & br_is_branch & m_used;
    assign init_done          = run;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        rr_d       = (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
        rd_ok_d    = rd_ok_q;
        // A read launched during the sweep may return an entry not yet cleared
        if (new_mem_request) rd_ok_d = run;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + LOG_I'(1);
                if (init_idx_q == LOG_I'(INIT_N - 1)) begin
                    state_d    = ST_RUN;
                    init_idx_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            rr_q       <= '0;
            rd_ok_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            rr_q       <= rr_d;
            rd_ok_q    <= rd_ok_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{next_pc, if_pc, br_pc};
endmodule
